// File: rtl/usb_cmd_decoder_if.sv
// Downstream word stream and decoded register bundle between the FX2 slave-FIFO
// bridge side and the host-command decoder.
interface usb_cmd_decoder_if;
   logic        dn_val;
   logic [15:0] dn_dat;
   logic [31:0] reg_freq;
   logic [15:0] reg_ctrl;
   logic [7:0]  reg_gain;
   logic        freq_upd;
   logic        ctrl_upd;
   logic        gain_upd;
   logic        frame_ok;
   logic [7:0]  err_cnt;
   logic        busy;

   modport master (
      output dn_val, dn_dat,
      input  reg_freq, reg_ctrl, reg_gain, freq_upd, ctrl_upd, gain_upd,
             frame_ok, err_cnt, busy
   );

   modport slave (
      input  dn_val, dn_dat,
      output reg_freq, reg_ctrl, reg_gain, freq_upd, ctrl_upd, gain_upd,
             frame_ok, err_cnt, busy
   );
endinterface

// File: rtl/usb_cmd_decoder.sv
// Framed host-command decoder: hunts SYNC, checks LEN and checksum, then commits
// freq/ctrl/gain registers with one-cycle update strobes; bad frames are counted.
module usb_cmd_decoder #(
   parameter logic [15:0] SYNC_WORD   = 16'hA55A,
   parameter int unsigned MAX_LEN     = 4,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input logic              clk_24m,
   input logic              rst_n,
   usb_cmd_decoder_if.slave bus
);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {
      S_HUNT, S_CMD, S_LEN, S_PAY, S_CHK, S_COMMIT
   } state_t;

   state_t        state;
   logic [15:0]   w;
   logic [15:0]   cmd;
   logic [15:0]   sum;
   logic [3:0]    len;
   logic [3:0]    idx;
   logic [15:0]   pay [MAX_LEN];
   logic [TW-1:0] tmo;
   logic          abort;
   logic          cmd_ok;

   assign w        = {bus.dn_dat[7:0], bus.dn_dat[15:8]};
   assign bus.busy = (state != S_HUNT);

   always_comb begin
      cmd_ok = ((cmd == 16'h0001) && (len == 4'd2)) ||
               ((cmd == 16'h0002) && (len == 4'd1)) ||
               ((cmd == 16'h0003) && (len == 4'd1));
   end

   // Every reject path funnels through abort so error counting lives in one place.
   always_comb begin
      abort = 1'b0;
      case (state)
         S_CMD, S_LEN, S_PAY, S_CHK: begin
            if (!bus.dn_val && (tmo == TW'(TIMEOUT_CYC - 1)))
               abort = 1'b1;
            if (bus.dn_val && (state == S_LEN) &&
                ((w == 16'd0) || (w > 16'(MAX_LEN))))
               abort = 1'b1;
            if (bus.dn_val && (state == S_CHK) && (w != sum))
               abort = 1'b1;
         end
         S_COMMIT: abort = !cmd_ok;
         default:  abort = 1'b0;
      endcase
   end

   always_ff @(posedge clk_24m) begin
      if (!rst_n) begin
         state        <= S_HUNT;
         cmd          <= '0;
         sum          <= '0;
         len          <= '0;
         idx          <= '0;
         tmo          <= '0;
         bus.reg_freq <= '0;
         bus.reg_ctrl <= '0;
         bus.reg_gain <= '0;
         bus.freq_upd <= 1'b0;
         bus.ctrl_upd <= 1'b0;
         bus.gain_upd <= 1'b0;
         bus.frame_ok <= 1'b0;
         bus.err_cnt  <= '0;
         for (int unsigned i = 0; i < MAX_LEN; i++)
            pay[i] <= '0;
      end else begin
         bus.freq_upd <= 1'b0;
         bus.ctrl_upd <= 1'b0;
         bus.gain_upd <= 1'b0;
         bus.frame_ok <= 1'b0;
         if (abort) begin
            state <= S_HUNT;
            tmo   <= '0;
            if (bus.err_cnt != 8'hFF)
               bus.err_cnt <= bus.err_cnt + 8'd1;
         end else begin
            case (state)
               S_HUNT: begin
                  tmo <= '0;
                  if (bus.dn_val && (w == SYNC_WORD))
                     state <= S_CMD;
               end
               S_CMD: begin
                  if (bus.dn_val) begin
                     cmd   <= w;
                     sum   <= w;
                     tmo   <= '0;
                     state <= S_LEN;
                  end else begin
                     tmo <= tmo + TW'(1);
                  end
               end
               S_LEN: begin
                  if (bus.dn_val) begin
                     len   <= w[3:0];
                     sum   <= sum + w;
                     idx   <= '0;
                     tmo   <= '0;
                     state <= S_PAY;
                  end else begin
                     tmo <= tmo + TW'(1);
                  end
               end
               S_PAY: begin
                  if (bus.dn_val) begin
                     pay[idx[IW-1:0]] <= w;
                     sum              <= sum + w;
                     idx              <= idx + 4'd1;
                     tmo              <= '0;
                     if (idx == len - 4'd1)
                        state <= S_CHK;
                  end else begin
                     tmo <= tmo + TW'(1);
                  end
               end
               S_CHK: begin
                  if (bus.dn_val) begin
                     tmo   <= '0;
                     state <= S_COMMIT;
                  end else begin
                     tmo <= tmo + TW'(1);
                  end
               end
               S_COMMIT: begin
                  state        <= S_HUNT;
                  bus.frame_ok <= 1'b1;
                  case (cmd)
                     16'h0001: begin
                        bus.reg_freq <= {pay[0], pay[1]};
                        bus.freq_upd <= 1'b1;
                     end
                     16'h0002: begin
                        bus.reg_ctrl <= pay[0];
                        bus.ctrl_upd <= 1'b1;
                     end
                     default: begin
                        bus.reg_gain <= pay[0][7:0];
                        bus.gain_upd <= 1'b1;
                     end
                  endcase
               end
               default: state <= S_HUNT;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_usb_cmd_decoder.sv
// Self-checking bench for usb_cmd_decoder: directed scenarios plus random frames
// checked against a frame-level outcome model.
module tb_usb_cmd_decoder;
   logic clk_24m = 1'b0;
   logic rst_n;

   usb_cmd_decoder_if bus();

   usb_cmd_decoder #(
      .SYNC_WORD  (16'hA55A),
      .MAX_LEN    (4),
      .TIMEOUT_CYC(64)
   ) dut (
      .clk_24m(clk_24m),
      .rst_n  (rst_n),
      .bus    (bus.slave)
   );

   always #20 clk_24m = ~clk_24m;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_fail   = 0;

   logic [31:0] m_freq;
   logic [15:0] m_ctrl;
   logic [7:0]  m_gain;
   int unsigned m_err;
   int unsigned m_nf = 0, m_nc = 0, m_ng = 0, m_nok = 0;
   int unsigned s_nf = 0, s_nc = 0, s_ng = 0, s_nok = 0, s_overlap = 0;

   // Pulse tally, sampled away from the active edge.
   always @(negedge clk_24m) begin
      if (bus.freq_upd === 1'b1) s_nf++;
      if (bus.ctrl_upd === 1'b1) s_nc++;
      if (bus.gain_upd === 1'b1) s_ng++;
      if (bus.frame_ok === 1'b1) s_nok++;
      if ((int'(bus.freq_upd) + int'(bus.ctrl_upd) + int'(bus.gain_upd)) > 1)
         s_overlap++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] csum(input logic [15:0] cmd, input logic [15:0] len,
                                        input logic [63:0] pay);
      logic [15:0] s;
      s = cmd + len;
      for (int i = 0; i < 4; i++)
         if (i < int'(len)) s = s + pay[63-16*i -: 16];
      return s;
   endfunction

   // 0 = rejected, 1 = freq, 2 = ctrl, 3 = gain
   function automatic int outcome(input logic [15:0] cmd, input logic [15:0] len,
                                  input logic [63:0] pay, input logic [15:0] chk,
                                  input int unsigned stall_len);
      if (stall_len >= 64) return 0;
      if (len == 16'd0 || len > 16'd4) return 0;
      if (chk != csum(cmd, len, pay)) return 0;
      if (cmd == 16'd1 && len == 16'd2) return 1;
      if (cmd == 16'd2 && len == 16'd1) return 2;
      if (cmd == 16'd3 && len == 16'd1) return 3;
      return 0;
   endfunction

   function automatic logic [7:0] exp_err();
      return (m_err > 255) ? 8'hFF : 8'(m_err);
   endfunction

   task automatic put_word(input logic [15:0] w);
      bus.dn_val = 1'b1;
      bus.dn_dat = {w[7:0], w[15:8]};
      @(negedge clk_24m);
   endtask

   task automatic idle(input int unsigned n);
      bus.dn_val = 1'b0;
      bus.dn_dat = 16'($urandom);
      repeat (n) @(negedge clk_24m);
   endtask

   task automatic send_frame(input logic [15:0] cmd, input logic [15:0] len,
                             input logic [63:0] pay, input logic [15:0] chk,
                             input int unsigned stall_pos, input int unsigned stall_len);
      logic [15:0] q[$];
      q = {16'hA55A, cmd, len};
      if (len >= 16'd1 && len <= 16'd4) begin
         for (int i = 0; i < int'(len); i++) q.push_back(pay[63-16*i -: 16]);
         q.push_back(chk);
      end
      for (int i = 0; i < q.size(); i++) begin
         if (stall_len > 0 && i == int'(stall_pos)) idle(stall_len);
         put_word(q[i]);
      end
   endtask

   task automatic frame(input string tag, input logic [15:0] cmd, input logic [15:0] len,
                        input logic [63:0] pay, input logic [15:0] chk,
                        input int unsigned stall_pos, input int unsigned stall_len);
      int o;
      o = outcome(cmd, len, pay, chk, stall_len);
      send_frame(cmd, len, pay, chk, stall_pos, stall_len);
      case (o)
         1: begin m_freq = pay[63:32]; m_nf++; end
         2: begin m_ctrl = pay[63:48]; m_nc++; end
         3: begin m_gain = pay[55:48]; m_ng++; end
         default: m_err++;
      endcase
      if (o != 0) m_nok++;
      idle(1);
      check({tag, "_strobes"}, {bus.freq_upd, bus.ctrl_upd, bus.gain_upd, bus.frame_ok},
            {o == 1, o == 2, o == 3, o != 0});
      check({tag, "_freq"}, bus.reg_freq, m_freq);
      check({tag, "_ctrl"}, bus.reg_ctrl, m_ctrl);
      check({tag, "_gain"}, bus.reg_gain, m_gain);
      check({tag, "_err"}, bus.err_cnt, exp_err());
      check({tag, "_busy"}, bus.busy, 1'b0);
      idle(1);
      check({tag, "_strobes_off"},
            {bus.freq_upd, bus.ctrl_upd, bus.gain_upd, bus.frame_ok}, 4'b0000);
   endtask

   initial begin
      logic [15:0] cmd, len, chk;
      logic [63:0] pay;
      int unsigned r;

      rst_n      = 1'b0;
      bus.dn_val = 1'b0;
      bus.dn_dat = '0;
      m_freq = '0; m_ctrl = '0; m_gain = '0; m_err = 0;
      repeat (3) @(negedge clk_24m);
      check("rst_regs", {bus.reg_freq ^ {bus.reg_ctrl, bus.reg_ctrl}, bus.reg_gain}, '0);
      check("rst_freq", bus.reg_freq, 32'h0);
      check("rst_misc", {bus.freq_upd, bus.ctrl_upd, bus.gain_upd, bus.frame_ok,
                         bus.busy, bus.err_cnt}, '0);
      rst_n = 1'b1;
      @(negedge clk_24m);

      put_word(16'h0000);
      put_word(16'hFFFF);
      idle(2);
      check("garbage_err", bus.err_cnt, 8'h00);
      check("garbage_busy", bus.busy, 1'b0);

      pay = 64'h1234_5678_0000_0000;
      frame("t1_freq", 16'h0001, 16'h0002, pay, csum(16'h0001, 16'h0002, pay), 0, 0);
      check("t1_freq_const", bus.reg_freq, 32'h1234_5678);

      frame("t2_badchk", 16'h0002, 16'h0001, 64'h0001_0000_0000_0000, 16'h0000, 0, 0);
      check("t2_err_const", bus.err_cnt, 8'd1);

      frame("t3_len5", 16'h0003, 16'h0005, '0, '0, 0, 0);
      frame("t3_len0", 16'h0003, 16'h0000, '0, '0, 0, 0);
      frame("t3_lenwide", 16'h0003, 16'h0101, '0, '0, 0, 0);
      pay = 64'h00C8_0000_0000_0000;
      frame("t3_gain", 16'h0003, 16'h0001, pay, csum(16'h0003, 16'h0001, pay), 0, 0);
      check("t3_gain_const", bus.reg_gain, 8'hC8);

      pay = 64'h00A5_0000_0000_0000;
      frame("t4_stall63", 16'h0002, 16'h0001, pay, csum(16'h0002, 16'h0001, pay), 3, 63);
      check("t4_ctrl_const", bus.reg_ctrl, 16'h00A5);
      pay = 64'h005A_0000_0000_0000;
      frame("t4_stall64", 16'h0002, 16'h0001, pay, csum(16'h0002, 16'h0001, pay), 3, 64);

      frame("unk_cmd", 16'h0007, 16'h0001, pay, csum(16'h0007, 16'h0001, pay), 0, 0);
      frame("len_mis", 16'h0001, 16'h0001, pay, csum(16'h0001, 16'h0001, pay), 0, 0);

      for (int i = 0; i < 40; i++) begin
         r   = $urandom_range(0, 3);
         cmd = (r == 0) ? 16'($urandom_range(4, 16'hFFFF)) : 16'(r);
         if ($urandom_range(0, 1) == 1) len = (cmd == 16'd1) ? 16'd2 : 16'd1;
         else                           len = 16'($urandom_range(0, 6));
         pay = {32'($urandom), 32'($urandom)};
         chk = csum(cmd, len, pay);
         if ($urandom_range(0, 4) == 0) chk = chk ^ (16'd1 << $urandom_range(0, 15));
         frame("rnd", cmd, len, pay, chk, 0, 0);
      end

      for (int i = 0; i < 300; i++) begin
         put_word(16'hA55A);
         put_word(16'h0001);
         put_word(16'h0000);
         idle(1);
      end
      m_err += 300;
      idle(2);
      check("t5_sat", bus.err_cnt, 8'hFF);
      check("t5_busy", bus.busy, 1'b0);

      put_word(16'hA55A);
      put_word(16'h0001);
      put_word(16'h0002);
      put_word(16'h1111);
      rst_n      = 1'b0;
      bus.dn_val = 1'b0;
      @(negedge clk_24m);
      rst_n = 1'b1;
      m_freq = '0; m_ctrl = '0; m_gain = '0; m_err = 0;
      check("t6_freq", bus.reg_freq, 32'h0);
      check("t6_ctrl_gain", {bus.reg_ctrl, bus.reg_gain}, 24'h0);
      check("t6_misc", {bus.freq_upd, bus.ctrl_upd, bus.gain_upd, bus.frame_ok,
                        bus.busy, bus.err_cnt}, '0);
      pay = 64'h0001_0000_0000_0000;
      frame("t6_ctrl", 16'h0002, 16'h0001, pay, csum(16'h0002, 16'h0001, pay), 0, 0);
      check("t6_ctrl_const", bus.reg_ctrl, 16'h0001);

      idle(2);
      check("cnt_freq_upd", s_nf, m_nf);
      check("cnt_ctrl_upd", s_nc, m_nc);
      check("cnt_gain_upd", s_ng, m_ng);
      check("cnt_frame_ok", s_nok, m_nok);
      check("upd_overlap", s_overlap, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
